timer_tick_ctrl: RTL and testbench

- Control and prescaler stage directly upstream of the cascaded digit-timer chain.
- Divides the system clock into one-cycle decrement pulses for the least-significant digit's borrow_dn input.
- Drives the chain's load (RST) and most-significant-digit enable (noborrow_up).
- Stops issuing pulses when the chain reports all-zero via the MSD's noborrow_dn; sequences start/pause/restart from pre-shaped button pulses.

---
 rtl/timer_tick_ctrl_if.sv | 31 +++
 rtl/timer_tick_ctrl.sv | 113 +++++++++++
 tb/tb_timer_tick_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/timer_tick_ctrl_if.sv
// Control/status bundle between timer_tick_ctrl and its surroundings.
// reload_cnt exists only when TIMER_AUTORELOAD_EN is defined.
interface timer_tick_ctrl_if;
  logic       start_p;
  logic       pause_p;
  logic       chain_zero;
  logic       digit_load;
  logic       tick_dn;
  logic       chain_en;
  logic       running;
  logic       timeout;
`ifdef TIMER_AUTORELOAD_EN
  logic [7:0] reload_cnt;
`endif

  modport master (
    output start_p, pause_p, chain_zero,
    input  digit_load, tick_dn, chain_en, running, timeout
`ifdef TIMER_AUTORELOAD_EN
    , input reload_cnt
`endif
  );

  modport slave (
    input  start_p, pause_p, chain_zero,
    output digit_load, tick_dn, chain_en, running, timeout
`ifdef TIMER_AUTORELOAD_EN
    , output reload_cnt
`endif
  );
endinterface

// File: rtl/timer_tick_ctrl.sv
// Prescaler + start/pause/done sequencer in front of the digit-timer chain.
// Optional TIMER_AUTORELOAD_EN: DONE lasts one cycle, then reloads; adds reload_cnt.
module timer_tick_ctrl #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned LOAD_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  timer_tick_ctrl_if.slave bus
);
  localparam int unsigned   PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    LC_MAX  = 4'(LOAD_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;

  state_t        state, nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [3:0]    lc, lc_nxt;
  logic          tick_nxt;
  logic          digit_load, tick_dn, chain_en, running, timeout;

  always_comb begin
    nxt      = state;
    pre_nxt  = pre;
    lc_nxt   = lc;
    tick_nxt = 1'b0;
    case (state)
      IDLE: if (bus.start_p) begin
        nxt    = LOAD;
        lc_nxt = '0;
      end
      LOAD: begin
        if (bus.start_p) lc_nxt = '0;
        else if (lc == LC_MAX) begin
          nxt     = RUN;
          pre_nxt = '0;
        end else lc_nxt = lc + 4'd1;
      end
      RUN: begin
        if (bus.start_p) begin
          nxt     = LOAD;
          lc_nxt  = '0;
          pre_nxt = '0;
        end else if (bus.chain_zero) begin
          // a tick due this cycle is dropped: the chain is already empty
          nxt     = DONE;
          pre_nxt = '0;
        end else if (bus.pause_p) nxt = PAUSE;
        else begin
          tick_nxt = (pre == PRE_MAX);
          pre_nxt  = (pre == PRE_MAX) ? '0 : pre + 1'b1;
        end
      end
      PAUSE: begin
        if (bus.start_p) begin
          nxt    = LOAD;
          lc_nxt = '0;
        end else if (bus.pause_p) nxt = RUN;
      end
      DONE: begin
`ifdef TIMER_AUTORELOAD_EN
        nxt    = LOAD;
        lc_nxt = '0;
`else
        if (bus.start_p) begin
          nxt    = LOAD;
          lc_nxt = '0;
        end
`endif
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pre        <= '0;
      lc         <= '0;
      digit_load <= 1'b0;
      tick_dn    <= 1'b0;
      chain_en   <= 1'b0;
      running    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= nxt;
      pre        <= pre_nxt;
      lc         <= lc_nxt;
      digit_load <= (nxt == LOAD);
      tick_dn    <= tick_nxt;
      chain_en   <= (nxt == RUN);
      running    <= (nxt == RUN);
      timeout    <= (nxt == DONE);
    end
  end

  assign bus.digit_load = digit_load;
  assign bus.tick_dn    = tick_dn;
  assign bus.chain_en   = chain_en;
  assign bus.running    = running;
  assign bus.timeout    = timeout;

`ifdef TIMER_AUTORELOAD_EN
  logic [7:0] reload_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reload_cnt <= '0;
    else if (nxt == DONE && state != DONE) reload_cnt <= reload_cnt + 8'd1;
  end
  assign bus.reload_cnt = reload_cnt;
`endif
endmodule

// File: tb/tb_timer_tick_ctrl.sv
// Randomized scoreboard bench for timer_tick_ctrl against a countdown-style model.
// Build with TIMER_AUTORELOAD_EN to exercise the auto-reload variant (TICK_DIV=1).
module tb_timer_tick_ctrl;
`ifdef TIMER_AUTORELOAD_EN
  localparam int TD = 1;
  localparam bit AR = 1'b1;
`else
  localparam int TD = 4;
  localparam bit AR = 1'b0;
`endif
  localparam int LC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  timer_tick_ctrl_if bus();
  timer_tick_ctrl #(.TICK_DIV(TD), .LOAD_CYC(LC)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {
    logic       dl, tick, en, run, to;
    logic [7:0] rc;
  } obs_t;

  typedef enum {M_IDLE, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_t;

  obs_t  exp_q[$];
  int    n_chk = 0, n_fail = 0, cyc = 0;
  mode_t mode = M_IDLE;
  int    load_left = 0, cyc_to_tick = 0, dones = 0;

  function automatic obs_t sample();
    obs_t o;
    o.dl = bus.digit_load; o.tick = bus.tick_dn; o.en = bus.chain_en;
    o.run = bus.running;   o.to = bus.timeout;
`ifdef TIMER_AUTORELOAD_EN
    o.rc = bus.reload_cnt;
`else
    o.rc = 8'd0;
`endif
    return o;
  endfunction

  function automatic void check(string name, obs_t act, obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got(dl,tick,en,run,to,rc)=%b,%b,%b,%b,%b,%0d want=%b,%b,%b,%b,%b,%0d",
               name, cyc, act.dl, act.tick, act.en, act.run, act.to, act.rc,
               exp.dl, exp.tick, exp.en, exp.run, exp.to, exp.rc);
    end
  endfunction

  // Model: count remaining load cycles and cycles until the next tick.
  function automatic obs_t model_step(bit s, bit p, bit z);
    obs_t o;
    bit   tick = 1'b0;
    case (mode)
      M_IDLE:  if (s) begin mode = M_LOAD; load_left = LC; end
      M_LOAD:  if (s) load_left = LC;
               else if (load_left == 1) begin mode = M_RUN; cyc_to_tick = TD; end
               else load_left--;
      M_RUN:   if (s) begin mode = M_LOAD; load_left = LC; end
               else if (z) begin mode = M_DONE; dones++; end
               else if (p) mode = M_PAUSE;
               else begin
                 cyc_to_tick--;
                 if (cyc_to_tick == 0) begin tick = 1'b1; cyc_to_tick = TD; end
               end
      M_PAUSE: if (s) begin mode = M_LOAD; load_left = LC; end
               else if (p) mode = M_RUN;
      M_DONE:  if (s || AR) begin mode = M_LOAD; load_left = LC; end
      default: mode = M_IDLE;
    endcase
    o.dl = (mode == M_LOAD); o.tick = tick; o.en = (mode == M_RUN);
    o.run = (mode == M_RUN); o.to = (mode == M_DONE);
    o.rc = AR ? 8'(dones % 256) : 8'd0;
    return o;
  endfunction

  task automatic step(bit s, bit p, bit z);
    @(negedge clk);
    bus.start_p = s; bus.pause_p = p; bus.chain_zero = z;
    @(posedge clk);
    exp_q.push_back(model_step(s, p, z));
    cyc++;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    bus.start_p = 1'b0; bus.pause_p = 1'b0; bus.chain_zero = 1'b0;
    #2 rst = 1'b0;
    #1 check("async_reset", sample(), '0);
    exp_q.delete();
    mode = M_IDLE; load_left = 0; cyc_to_tick = 0; dones = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", sample(), '0);
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", sample(), e);
      end
    end
  end

  initial begin
    bus.start_p = 1'b0; bus.pause_p = 1'b0; bus.chain_zero = 1'b0;
    do_reset();
    // start, load, run through several ticks
    step(0, 0, 0); step(1, 0, 0);
    repeat (16) step(0, 0, 0);
    // pause mid-period, long pause, resume
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    // start and pause together in RUN: start wins
    step(1, 1, 0);
    repeat (9) step(0, 0, 0);
    // chain empties; timeout holds until start
    step(0, 0, 1);
    repeat (20) step(0, 0, 0);
    step(1, 0, 0);
    repeat (8) step(0, 0, 0);
    // reset mid-RUN, then start+pause together in IDLE
    do_reset();
    step(1, 1, 0);
    repeat (6) step(0, 0, 0);
    // chain already empty on RUN entry
    step(1, 0, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    repeat (3) step(0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      else step($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 24) == 0);
    end

    // chain stuck at zero: every RUN entry ends immediately
    for (int i = 0; i < 1200; i++)
      step(!AR && (i % 25 == 0), $urandom_range(0, 3) == 0, 1'b1);

    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
